// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: state encodings,
// default reset vector and word-alignment helper.
package fetch_ctrl_pkg;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding
// imem request/grant/response handshake and presents instructions to decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        f_valid_o,
    output logic [31:0] f_pc_o,
    output logic [31:0] f_instr_o,
    output logic        misalign_o
);

    // Handshake: imem_req_o/imem_addr_o are held until a cycle with imem_gnt_i
    // (a redirect may retarget the address while ungranted); exactly one
    // response (imem_rvalid_i) follows each grant and is only looked at in WAIT.
    logic [1:0]  state;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] target;

    assign target      = align_word(redir_pc_i);
    assign imem_req_o  = (state == ST_REQ);
    assign imem_addr_o = pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_RST;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            f_valid_o  <= 1'b0;
            f_pc_o     <= 32'h0;
            f_instr_o  <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redir_i & (|redir_pc_i[1:0]);
            case (state)
                ST_RST: begin
                    if (redir_i) pc <= target;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (redir_i) begin
                        pc <= target;
                        // The old address was accepted; its response must be dropped.
                        if (imem_gnt_i) begin
                            kill  <= 1'b1;
                            state <= ST_WAIT;
                        end
                    end else if (imem_gnt_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redir_i) begin
                        pc <= target;
                        if (imem_rvalid_i) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            f_instr_o <= imem_rdata_i;
                            f_pc_o    <= pc;
                            f_valid_o <= 1'b1;
                            pc        <= pc + 32'd4;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redir_i) begin
                        f_valid_o <= 1'b0;
                        pc        <= target;
                        state     <= ST_REQ;
                    end else if (!stall_i) begin
                        f_valid_o <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a scripted memory responder drives imem,
// delivered instructions are checked against an expected {pc,instr} queue.
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redir_i = 1'b0;
    logic [31:0] redir_pc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        f_valid_o;
    logic [31:0] f_pc_o;
    logic [31:0] f_instr_o;
    logic        misalign_o;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redir_i(redir_i), .redir_pc_i(redir_pc_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .f_valid_o(f_valid_o), .f_pc_o(f_pc_o), .f_instr_o(f_instr_o),
        .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at a negedge; an instruction is consumed at the coming
    // posedge if it is presented, decode is not stalled and no redirect hits.
    task automatic tick();
        logic [63:0] e;
        if (f_valid_o && !stall_i && !redir_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fvalid", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("f_pc_instr", {f_pc_o, f_instr_o}, e);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk("rst_addr", 64'(imem_addr_o), 64'h0);
        chk("rst_fvalid", 64'(f_valid_o), 64'd0);
        chk("rst_fpc", 64'(f_pc_o), 64'h0);
        chk("rst_finstr", 64'(f_instr_o), 64'h0);
        chk("rst_misalign", 64'(misalign_o), 64'd0);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (!imem_req_o && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 64'(imem_req_o), 64'd1);
        chk("req_addr", 64'(imem_addr_o), 64'(addr));
    endtask

    task automatic grant(input int delay, input logic [31:0] addr);
        for (int i = 0; i < delay; i++) begin
            chk("req_held", 64'(imem_req_o), 64'd1);
            chk("addr_stable", 64'(imem_addr_o), 64'(addr));
            tick();
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk("req_low_in_wait", 64'(imem_req_o), 64'd0);
    endtask

    task automatic respond(input logic [31:0] data, input bit push, input logic [31:0] pc);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        if (push) exp_q.push_back({pc, data});
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
    endtask

    task automatic fetch(input logic [31:0] addr, input int delay, input logic [31:0] data);
        wait_req(addr);
        grant(delay, addr);
        respond(data, 1'b1, addr);
        chk("fvalid_latency", 64'(f_valid_o), 64'd1);
        tick();
        chk("fvalid_consumed", 64'(f_valid_o), 64'd0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redir_i    = 1'b1;
        redir_pc_i = tgt;
        tick();
        redir_i    = 1'b0;
    endtask

    initial begin
        // Reset release, zero-wait in-order fetch of 0, 4, 8.
        apply_reset();
        fetch(32'h0, 0, $urandom);
        fetch(32'h4, 0, $urandom);
        fetch(32'h8, 0, $urandom);

        // Delayed grant at 0x4, then redirect coinciding with grant of 0x8.
        apply_reset();
        fetch(32'h0, 0, $urandom);
        fetch(32'h4, 3, $urandom);
        wait_req(32'h8);
        imem_gnt_i = 1'b1;
        redir_i    = 1'b1;
        redir_pc_i = 32'h100;
        tick();
        imem_gnt_i = 1'b0;
        redir_i    = 1'b0;
        chk("kill_wait_noreq", 64'(imem_req_o), 64'd0);
        chk("aligned_no_misalign", 64'(misalign_o), 64'd0);
        respond($urandom, 1'b0, 32'h8);
        chk("stale_dropped", 64'(f_valid_o), 64'd0);
        fetch(32'h100, 0, $urandom);

        // Redirect in REQ without grant retargets the address next cycle.
        wait_req(32'h104);
        redirect(32'h10);
        chk("redir_req_live", 64'(imem_req_o), 64'd1);
        chk("redir_req_addr", 64'(imem_addr_o), 64'h10);

        // Stall in HOLD for 4 cycles.
        wait_req(32'h10);
        grant(0, 32'h10);
        stall_i = 1'b1;
        respond(32'h0000_0013, 1'b1, 32'h10);
        for (int i = 0; i < 4; i++) begin
            chk("hold_fvalid", 64'(f_valid_o), 64'd1);
            chk("hold_fpc", 64'(f_pc_o), 64'h10);
            chk("hold_finstr", 64'(f_instr_o), 64'h13);
            chk("hold_noreq", 64'(imem_req_o), 64'd0);
            tick();
        end
        stall_i = 1'b0;
        tick();
        chk("hold_released", 64'(f_valid_o), 64'd0);

        // Misaligned redirect squashes the presented instruction.
        wait_req(32'h14);
        grant(0, 32'h14);
        stall_i = 1'b1;
        respond($urandom, 1'b0, 32'h14);
        chk("hold2_fvalid", 64'(f_valid_o), 64'd1);
        redirect(32'h203);
        stall_i = 1'b0;
        chk("squash_fvalid", 64'(f_valid_o), 64'd0);
        chk("misalign_pulse", 64'(misalign_o), 64'd1);
        chk("misalign_target", 64'(imem_addr_o), 64'h200);
        tick();
        chk("misalign_once", 64'(misalign_o), 64'd0);

        // Redirect in WAIT before the response arrives.
        wait_req(32'h200);
        grant(0, 32'h200);
        redirect(32'h300);
        chk("wait_redir_noreq", 64'(imem_req_o), 64'd0);
        tick();
        respond($urandom, 1'b0, 32'h200);
        chk("wait_redir_dropped", 64'(f_valid_o), 64'd0);
        wait_req(32'h300);

        // Reset in WAIT, stale rvalid after release is ignored.
        grant(0, 32'h300);
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = $urandom;
        tick();
        tick();
        imem_rvalid_i = 1'b0;
        chk("post_rst_fvalid", 64'(f_valid_o), 64'd0);
        chk("post_rst_finstr", 64'(f_instr_o), 64'h0);
        fetch(32'h0, 0, $urandom);

        // PC increment wraps at the top of the address space.
        wait_req(32'h4);
        redirect(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 1, $urandom);
        wait_req(32'h0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
